snax_alu_csr_ctrl: RTL and testbench

Second-generation CSR and job controller for the SNAX ALU accelerator. It adds a one-deep shadow (pending) job slot so software can queue the next job while the current one runs, and the controller hands off back-to-back with no idle cycle. It also adds an abort command, a zero-length error flag, a frozen per-job cycle counter and a completed-job counter. It sits between the CSR manager and the ALU PE array, driving mode and ready directly to the PEs.

---
 rtl/snax_alu_csr_pkg.sv | 28 ++
 rtl/snax_alu_job_slot.sv | 56 +++++
 rtl/snax_alu_csr_ctrl.sv | 174 +++++++++++++++++
 tb/tb_snax_alu_csr_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/snax_alu_csr_pkg.sv
// Shared types and CSR layout constants for the SNAX ALU CSR/job controller.
package snax_alu_csr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // RW CSR indices
  localparam int unsigned ModeIdx   = 0;
  localparam int unsigned LenIdx    = 1;
  localparam int unsigned CmdIdx    = 2;

  // RO CSR indices
  localparam int unsigned StatusIdx = 0;
  localparam int unsigned PerfIdx   = 1;
  localparam int unsigned JobsIdx   = 2;

  // Command register bits
  localparam int unsigned StartBit  = 0;
  localparam int unsigned AbortBit  = 1;

  // Status register bits
  localparam int unsigned BusyBit   = 0;
  localparam int unsigned PendBit   = 1;
  localparam int unsigned ErrBit    = 2;

endpackage

// File: rtl/snax_alu_job_slot.sv
// One-deep shadow job slot: holds the next job's mode/length and a pending flag.
module snax_alu_job_slot #(
  parameter int unsigned ModeWidth = 2,
  parameter int unsigned LenWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,   // capture mode/len from the write
  input  logic [ModeWidth-1:0] mode_i,
  input  logic [LenWidth-1:0]  len_i,
  input  logic                 arm_i,    // mark the shadow job as pending
  input  logic                 take_i,   // active slot consumes the shadow job
  input  logic                 flush_i,  // drop the shadow job
  output logic [ModeWidth-1:0] mode_o,
  output logic [LenWidth-1:0]  len_o,
  output logic                 full_o
);

  logic [ModeWidth-1:0] mode_q, mode_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic                 pend_q, pend_d;

  // Next-state for the shadow registers and pending flag; clearing beats arming.
  always_comb begin
    mode_d = mode_q;
    len_d  = len_q;
    pend_d = pend_q;
    if (load_i) begin
      mode_d = mode_i;
      len_d  = len_i;
    end
    if (take_i || flush_i) begin
      pend_d = 1'b0;
    end else if (arm_i) begin
      pend_d = 1'b1;
    end
  end

  // Shadow register bank with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= '0;
      len_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      len_q  <= len_d;
      pend_q <= pend_d;
    end
  end

  assign mode_o = mode_q;
  assign len_o  = len_q;
  assign full_o = pend_q;

endmodule

// File: rtl/snax_alu_csr_ctrl.sv
// CSR and job controller for the SNAX ALU: active job plus one queued job,
// abort, zero-length error flag, per-job cycle counter and job counter.
module snax_alu_csr_ctrl
  import snax_alu_csr_pkg::*;
#(
  parameter int unsigned RegRWCount   = 3,
  parameter int unsigned RegROCount   = 3,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned ModeWidth    = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
  input  logic                               csr_reg_set_valid_i,
  output logic                               csr_reg_set_ready_o,
  output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
  input  logic                               acc_output_success_i,
  output logic                               acc_ready_o,
  output logic [ModeWidth-1:0]               csr_alu_config_o,
  output logic                               acc_job_done_o
);

  localparam logic [RegDataWidth-1:0] One = RegDataWidth'(1);

  state_e                  state_q, state_d;
  logic [ModeWidth-1:0]    act_mode_q, act_mode_d;
  logic [RegDataWidth-1:0] act_len_q, act_len_d;
  logic [RegDataWidth-1:0] len_cnt_q, len_cnt_d;
  logic [RegDataWidth-1:0] perf_q, perf_d;
  logic [RegDataWidth-1:0] jobs_q, jobs_d;
  logic                    err_q, err_d;

  logic [RegDataWidth-1:0] wr_mode_full, wr_len, wr_cmd;
  logic [ModeWidth-1:0]    wr_mode;
  logic                    wr_start, wr_abort, accept, busy, last;

  logic                    slot_load, slot_arm, slot_take, slot_flush, slot_full;
  logic [ModeWidth-1:0]    slot_mode;
  logic [RegDataWidth-1:0] slot_len;
  logic [RegDataWidth-1:0] perf_inc;
  logic                    unused_bits;

  assign wr_mode_full = csr_reg_set_i[ModeIdx*RegDataWidth +: RegDataWidth];
  assign wr_len       = csr_reg_set_i[LenIdx*RegDataWidth  +: RegDataWidth];
  assign wr_cmd       = csr_reg_set_i[CmdIdx*RegDataWidth  +: RegDataWidth];
  assign wr_mode      = wr_mode_full[ModeWidth-1:0];
  assign wr_start     = wr_cmd[StartBit];
  assign wr_abort     = wr_cmd[AbortBit];
  assign unused_bits  = ^{wr_mode_full, wr_cmd};

  assign csr_reg_set_ready_o = !slot_full;
  assign accept   = csr_reg_set_valid_i && csr_reg_set_ready_o;
  assign busy     = (state_q == BUSY);
  assign last     = busy && acc_output_success_i && (len_cnt_q == act_len_q - One);
  assign perf_inc = (perf_q == '1) ? perf_q : perf_q + One;

  snax_alu_job_slot #(
    .ModeWidth (ModeWidth),
    .LenWidth  (RegDataWidth)
  ) i_job_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (slot_load),
    .mode_i  (wr_mode),
    .len_i   (wr_len),
    .arm_i   (slot_arm),
    .take_i  (slot_take),
    .flush_i (slot_flush),
    .mode_o  (slot_mode),
    .len_o   (slot_len),
    .full_o  (slot_full)
  );

  // Next-state and outputs: abort > completion/hand-off > start > plain write.
  always_comb begin
    state_d        = state_q;
    act_mode_d     = act_mode_q;
    act_len_d      = act_len_q;
    len_cnt_d      = len_cnt_q;
    perf_d         = busy ? perf_inc : perf_q;
    jobs_d         = jobs_q;
    err_d          = err_q;
    slot_load      = 1'b0;
    slot_arm       = 1'b0;
    slot_take      = 1'b0;
    slot_flush     = 1'b0;
    acc_job_done_o = 1'b0;

    if (accept && wr_abort) begin
      state_d    = IDLE;
      len_cnt_d  = '0;
      slot_flush = 1'b1;
    end else if (last) begin
      acc_job_done_o = 1'b1;
      jobs_d         = jobs_q + One;
      len_cnt_d      = '0;
      if (slot_full) begin
        act_mode_d = slot_mode;
        act_len_d  = slot_len;
        slot_take  = 1'b1;
        perf_d     = '0;
      end else if (accept && wr_start && (wr_len != '0)) begin
        // Direct hand-off from the write; the shadow slot is bypassed.
        act_mode_d = wr_mode;
        act_len_d  = wr_len;
        perf_d     = '0;
      end else begin
        state_d = IDLE;
        // A non-launching write landing on the final beat still queues its fields.
        if (accept) begin
          slot_load = 1'b1;
          if (wr_start) err_d = 1'b1;
        end
      end
    end else if (busy) begin
      if (acc_output_success_i) len_cnt_d = len_cnt_q + One;
      if (accept) begin
        slot_load = 1'b1;
        if (wr_start) begin
          if (wr_len != '0) slot_arm = 1'b1;
          else              err_d    = 1'b1;
        end
      end
    end else if (accept) begin
      act_mode_d = wr_mode;
      act_len_d  = wr_len;
      if (wr_start) begin
        if (wr_len != '0) begin
          state_d   = BUSY;
          len_cnt_d = '0;
          perf_d    = '0;
          err_d     = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      act_mode_q <= '0;
      act_len_q  <= '0;
      len_cnt_q  <= '0;
      perf_q     <= '0;
      jobs_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_mode_q <= act_mode_d;
      act_len_q  <= act_len_d;
      len_cnt_q  <= len_cnt_d;
      perf_q     <= perf_d;
      jobs_q     <= jobs_d;
      err_q      <= err_d;
    end
  end

  // Read-only CSR bundle and PE-facing outputs.
  always_comb begin
    csr_reg_ro_set_o = '0;
    csr_reg_ro_set_o[StatusIdx*RegDataWidth + BusyBit] = busy;
    csr_reg_ro_set_o[StatusIdx*RegDataWidth + PendBit] = slot_full;
    csr_reg_ro_set_o[StatusIdx*RegDataWidth + ErrBit]  = err_q;
    csr_reg_ro_set_o[PerfIdx*RegDataWidth +: RegDataWidth] = perf_q;
    csr_reg_ro_set_o[JobsIdx*RegDataWidth +: RegDataWidth] = jobs_q;
  end

  assign acc_ready_o      = busy;
  assign csr_alu_config_o = act_mode_q;

endmodule

// File: tb/tb_snax_alu_csr_ctrl.sv
// Directed bench for snax_alu_csr_ctrl with a completion scoreboard.
module tb_snax_alu_csr_ctrl;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [3*W-1:0] csr_reg_set_i = '0;
  logic          csr_reg_set_valid_i = 1'b0;
  logic          csr_reg_set_ready_o;
  logic [3*W-1:0] csr_reg_ro_set_o;
  logic          acc_output_success_i = 1'b0;
  logic          acc_ready_o;
  logic [1:0]    csr_alu_config_o;
  logic          acc_job_done_o;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int done_seen = 0;
  logic [1:0] exp_q[$];   // expected mode of each job completion, in order

  snax_alu_csr_ctrl dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .csr_reg_set_i        (csr_reg_set_i),
    .csr_reg_set_valid_i  (csr_reg_set_valid_i),
    .csr_reg_set_ready_o  (csr_reg_set_ready_o),
    .csr_reg_ro_set_o     (csr_reg_ro_set_o),
    .acc_output_success_i (acc_output_success_i),
    .acc_ready_o          (acc_ready_o),
    .csr_alu_config_o     (csr_alu_config_o),
    .acc_job_done_o       (acc_job_done_o)
  );

  always #5 clk_i = ~clk_i;

  wire [W-1:0] ro_status = csr_reg_ro_set_o[0*W +: W];
  wire [W-1:0] ro_perf   = csr_reg_ro_set_o[1*W +: W];
  wire [W-1:0] ro_jobs   = csr_reg_ro_set_o[2*W +: W];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: each done pulse pops the scoreboard and checks the job mode.
  always @(negedge clk_i) begin
    if (acc_job_done_o === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) chk("done_unexpected", {31'b0, acc_job_done_o}, 0);
      else chk("done_mode", {30'b0, csr_alu_config_o}, {30'b0, exp_q.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] mode, input int len, input logic [1:0] cmd);
    csr_reg_set_i       = {30'b0, cmd, W'(len), 30'b0, mode};
    csr_reg_set_valid_i = 1'b1;
    cyc();
    csr_reg_set_valid_i = 1'b0;
    csr_reg_set_i       = '0;
  endtask

  task automatic succ(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      acc_output_success_i = 1'b1;
      cyc();
      acc_output_success_i = 1'b0;
      for (int g = 0; g < gap; g++) cyc();
    end
  endtask

  int d0;

  initial begin
    // Reset state
    cyc(); cyc();
    rst_i = 1'b0;
    chk("rst_status", ro_status, 0);
    chk("rst_perf", ro_perf, 0);
    chk("rst_jobs", ro_jobs, 0);
    chk("rst_ready", {31'b0, csr_reg_set_ready_o}, 1);
    chk("rst_acc_ready", {31'b0, acc_ready_o}, 0);
    chk("rst_mode", {30'b0, csr_alu_config_o}, 0);

    // 1. Basic job: mode 2, length 4, spaced successes
    exp_q.push_back(2'd2);
    wr(2'd2, 4, 2'b01);
    chk("t1_busy", ro_status, 1);
    chk("t1_acc_ready", {31'b0, acc_ready_o}, 1);
    chk("t1_mode", {30'b0, csr_alu_config_o}, 2);
    succ(3, 1);
    chk("t1_still_busy", ro_status, 1);
    succ(1, 0);
    chk("t1_idle", ro_status, 0);
    chk("t1_jobs", ro_jobs, 1);
    chk("t1_perf", ro_perf, 7);
    chk("t1_done_cnt", done_seen, 1);
    cyc();
    chk("t1_perf_frozen", ro_perf, 7);

    // 2. Queued job hands off with no idle cycle
    exp_q.push_back(2'd3);
    wr(2'd3, 3, 2'b01);
    exp_q.push_back(2'd1);
    wr(2'd1, 2, 2'b01);
    chk("t2_ready_low", {31'b0, csr_reg_set_ready_o}, 0);
    chk("t2_pending", ro_status, 3);
    chk("t2_mode_old", {30'b0, csr_alu_config_o}, 3);
    succ(3, 0);
    chk("t2_handoff_busy", {31'b0, acc_ready_o}, 1);
    chk("t2_handoff_status", ro_status, 1);
    chk("t2_mode_new", {30'b0, csr_alu_config_o}, 1);
    chk("t2_jobs_mid", ro_jobs, 2);
    chk("t2_perf_reset", ro_perf, 0);
    succ(2, 0);
    chk("t2_jobs", ro_jobs, 3);
    chk("t2_idle", ro_status, 0);
    chk("t2_perf", ro_perf, 2);

    // 3. Same-cycle hand-off from a new start
    exp_q.push_back(2'd2);
    wr(2'd2, 1, 2'b01);
    exp_q.push_back(2'd3);
    csr_reg_set_i        = {30'b0, 2'b01, W'(2), 30'b0, 2'd3};
    csr_reg_set_valid_i  = 1'b1;
    acc_output_success_i = 1'b1;
    cyc();
    csr_reg_set_valid_i  = 1'b0;
    acc_output_success_i = 1'b0;
    chk("t3_status", ro_status, 1);
    chk("t3_mode", {30'b0, csr_alu_config_o}, 3);
    chk("t3_jobs_mid", ro_jobs, 4);
    succ(2, 1);
    chk("t3_jobs", ro_jobs, 5);
    chk("t3_idle", ro_status, 0);

    // 4. Abort drops the running job without a completion
    d0 = done_seen;
    wr(2'd1, 8, 2'b01);
    succ(3, 0);
    wr(2'd0, 0, 2'b10);
    chk("t4_idle", ro_status, 0);
    chk("t4_acc_ready", {31'b0, acc_ready_o}, 0);
    chk("t4_jobs", ro_jobs, 5);
    chk("t4_no_done", done_seen, d0);
    exp_q.push_back(2'd2);
    wr(2'd2, 1, 2'b01);
    succ(1, 0);
    chk("t4_jobs_after", ro_jobs, 6);
    chk("t4_idle_after", ro_status, 0);

    // 5. Zero length sets the sticky error, a valid start clears it
    wr(2'd1, 0, 2'b01);
    chk("t5_err", ro_status, 4);
    cyc();
    chk("t5_err_sticky", ro_status, 4);
    exp_q.push_back(2'd1);
    wr(2'd1, 2, 2'b01);
    chk("t5_err_clear", ro_status, 1);
    succ(2, 0);
    chk("t5_jobs", ro_jobs, 7);

    // 6. Reset while a job runs and another is pending
    wr(2'd2, 3, 2'b01);
    wr(2'd1, 2, 2'b01);
    chk("t6_pending", ro_status, 3);
    d0 = done_seen;
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("t6_status", ro_status, 0);
    chk("t6_perf", ro_perf, 0);
    chk("t6_jobs", ro_jobs, 0);
    chk("t6_ready", {31'b0, csr_reg_set_ready_o}, 1);
    chk("t6_acc_ready", {31'b0, acc_ready_o}, 0);
    chk("t6_mode", {30'b0, csr_alu_config_o}, 0);
    succ(3, 0);
    chk("t6_ignored_jobs", ro_jobs, 0);
    chk("t6_ignored_done", done_seen, d0);
    chk("t6_ignored_status", ro_status, 0);

    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
